// File: rtl/hex_parser_pkg.sv
// Shared constants for the ASCII hex parser: character codes, FSM state encoding, error causes.
// Imported by the parser top and its character-decoder sub-module.
package hex_parser_pkg;

  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_ESC = 8'h1B;
  localparam logic [7:0] CHAR_0   = 8'h30;
  localparam logic [7:0] CHAR_9   = 8'h39;
  localparam logic [7:0] CHAR_A   = 8'h41;
  localparam logic [7:0] CHAR_F   = 8'h46;
  localparam logic [7:0] CHAR_a   = 8'h61;
  localparam logic [7:0] CHAR_f   = 8'h66;
  localparam logic [7:0] CHAR_x   = 8'h78;
  localparam logic [7:0] CHAR_X   = 8'h58;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ZERO    = 2'd1;
  localparam state_t ST_ACCUM   = 2'd2;
  localparam state_t ST_DISCARD = 2'd3;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_INVALID  = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_EMPTY    = 2'd3;

endpackage

// File: rtl/ascii_to_binary_hex.sv
// Combinational ASCII -> hex nibble decoder, inverse of binary_to_ascii_hex; zero latency, no flow control.
// nibble is 0 whenever is_hex is low.
module ascii_to_binary_hex
  import hex_parser_pkg::*;
(
  input  logic [7:0] char_in,
  output logic       is_hex,
  output logic [3:0] nibble
);

  logic is_digit;
  logic is_upper;
  logic is_lower;

  assign is_digit = (char_in >= CHAR_0) && (char_in <= CHAR_9);
  assign is_upper = (char_in >= CHAR_A) && (char_in <= CHAR_F);
  assign is_lower = (char_in >= CHAR_a) && (char_in <= CHAR_f);
  assign is_hex   = is_digit || is_upper || is_lower;

  // Letters 'A'/'a' have low nibble 1, so adding 9 lands on 10.
  always_comb begin
    nibble = 4'd0;
    if (is_digit) begin
      nibble = char_in[3:0];
    end else if (is_upper || is_lower) begin
      nibble = char_in[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/hex_parser.sv
// Parses a CR/LF-terminated ASCII hex number (optional 0x prefix) into a 32-bit value.
// Result or error pulses 1 cycle after the terminator; one char per cycle, no backpressure.
module hex_parser
  import hex_parser_pkg::*;
#(
  parameter int MAX_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic [31:0] number_out,
  output logic        number_valid,
  output logic [3:0]  digit_count,
  output logic        error,
  output logic [1:0]  err_code,
  output logic        busy
);

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  count_q, count_d;
  logic        prefix_q, prefix_d;
  logic [31:0] num_q, num_d;
  logic [3:0]  dcnt_q, dcnt_d;
  logic        nvld_q, nvld_d;
  logic        err_q, err_d;
  logic [1:0]  ecode_q, ecode_d;

  logic        is_hex;
  logic [3:0]  nibble;
  logic        is_term, is_esc, is_x, at_max;

  ascii_to_binary_hex u_dec (
    .char_in (char_in),
    .is_hex  (is_hex),
    .nibble  (nibble)
  );

  assign is_term = (char_in == CHAR_CR) || (char_in == CHAR_LF);
  assign is_esc  = (char_in == CHAR_ESC);
  assign is_x    = (char_in == CHAR_x) || (char_in == CHAR_X);
  assign at_max  = (count_q == 4'(MAX_DIGITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      count_q  <= '0;
      prefix_q <= 1'b0;
      num_q    <= '0;
      dcnt_q   <= '0;
      nvld_q   <= 1'b0;
      err_q    <= 1'b0;
      ecode_q  <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      prefix_q <= prefix_d;
      num_q    <= num_d;
      dcnt_q   <= dcnt_d;
      nvld_q   <= nvld_d;
      err_q    <= err_d;
      ecode_q  <= ecode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (char_valid) begin
      if (is_esc) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (is_hex)        state_d = (nibble == 4'd0) ? ST_ZERO : ST_ACCUM;
            else if (!is_term) state_d = ST_DISCARD;
          end
          ST_ZERO, ST_ACCUM: begin
            if (is_hex)                            state_d = at_max ? ST_DISCARD : ST_ACCUM;
            else if (is_term)                      state_d = ST_IDLE;
            else if (is_x && state_q == ST_ZERO)   state_d = ST_ACCUM;
            else                                   state_d = ST_DISCARD;
          end
          default: begin
            if (is_term) state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  // Datapath and registered-output next values; the partial number is cleared on every exit path.
  always_comb begin
    acc_d    = acc_q;
    count_d  = count_q;
    prefix_d = prefix_q;
    num_d    = num_q;
    dcnt_d   = dcnt_q;
    nvld_d   = 1'b0;
    err_d    = 1'b0;
    ecode_d  = ecode_q;
    if (char_valid) begin
      if (is_esc) begin
        acc_d    = '0;
        count_d  = '0;
        prefix_d = 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (is_hex) begin
              acc_d    = {28'd0, nibble};
              count_d  = 4'd1;
              prefix_d = 1'b0;
            end else if (!is_term) begin
              err_d   = 1'b1;
              ecode_d = ERR_INVALID;
            end
          end
          ST_ZERO, ST_ACCUM: begin
            if (is_hex && !at_max) begin
              acc_d   = {acc_q[27:0], nibble};
              count_d = count_q + 4'd1;
            end else if (is_x && state_q == ST_ZERO) begin
              acc_d    = '0;
              count_d  = '0;
              prefix_d = 1'b1;
            end else begin
              acc_d    = '0;
              count_d  = '0;
              prefix_d = 1'b0;
              if (is_term && count_q != 4'd0) begin
                num_d  = acc_q;
                dcnt_d = count_q;
                nvld_d = 1'b1;
              end else begin
                err_d = 1'b1;
                if (is_hex)       ecode_d = ERR_OVERFLOW;
                else if (is_term) ecode_d = prefix_q ? ERR_EMPTY : ERR_INVALID;
                else              ecode_d = ERR_INVALID;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    number_out   = num_q;
    number_valid = nvld_q;
    digit_count  = dcnt_q;
    error        = err_q;
    err_code     = ecode_q;
    busy         = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_hex_parser.sv
// Directed self-checking bench for hex_parser; each task drives one scenario and checks inline.
module tb_hex_parser;

  logic        clk;
  logic        rst_n;
  logic [7:0]  char_in;
  logic        char_valid;
  logic [31:0] number_out;
  logic        number_valid;
  logic [3:0]  digit_count;
  logic        error;
  logic [1:0]  err_code;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int nv_pulses = 0;
  int err_pulses = 0;

  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] ESC = 8'h1B;

  hex_parser #(.MAX_DIGITS(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .char_in      (char_in),
    .char_valid   (char_valid),
    .number_out   (number_out),
    .number_valid (number_valid),
    .digit_count  (digit_count),
    .error        (error),
    .err_code     (err_code),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Drive one valid character, then observe outputs just after the edge that sampled it.
  task automatic send_char(input logic [7:0] c);
    @(negedge clk);
    char_in = c;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    nv_pulses += int'(number_valid);
    err_pulses += int'(error);
    checks++;
    if ((number_valid && error) !== 1'b0) begin
      errors++;
      $display("FAIL exclusive_pulses: number_valid=%b error=%b, required not both", number_valid, error);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic idle_cycle(input logic [7:0] c);
    @(negedge clk);
    char_in = c;
    char_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    char_in = 8'h00;
    char_valid = 1'b0;
    #3;
    checks++; if (number_out !== 32'h0) begin errors++; $display("FAIL reset_number_out: got %h required 0", number_out); end
    checks++; if (number_valid !== 1'b0) begin errors++; $display("FAIL reset_number_valid: got %b required 0", number_valid); end
    checks++; if (digit_count !== 4'd0) begin errors++; $display("FAIL reset_digit_count: got %0d required 0", digit_count); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b required 0", error); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code: got %0d required 0", err_code); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int e0 = err_pulses;
    send_char("1");
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b required 1", busy); end
    send_str("A2b");
    checks++; if (number_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b required 0", number_valid); end
    send_char(CR);
    checks++; if (number_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b required 1", number_valid); end
    checks++; if (number_out !== 32'h00001A2B) begin errors++; $display("FAIL basic_value: got %h required 00001a2b", number_out); end
    checks++; if (digit_count !== 4'd4) begin errors++; $display("FAIL basic_count: got %0d required 4", digit_count); end
    idle_cycle(8'h00);
    checks++; if (number_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %b required 0", number_valid); end
    checks++; if (err_pulses !== e0) begin errors++; $display("FAIL basic_no_error: got %0d error pulses required 0", err_pulses - e0); end
  endtask

  task automatic test_back_to_back();
    int n0 = nv_pulses;
    send_str("0xDEADBEEF");
    send_char(LF);
    checks++; if (number_out !== 32'hDEADBEEF || digit_count !== 4'd8 || number_valid !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h/%0d/%b required deadbeef/8/1", number_out, digit_count, number_valid); end
    send_char("7");
    checks++; if (number_valid !== 1'b0 || number_out !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_gap: got %b/%h required 0/deadbeef", number_valid, number_out); end
    send_char(LF);
    checks++; if (number_out !== 32'h7 || digit_count !== 4'd1 || number_valid !== 1'b1) begin errors++; $display("FAIL b2b_second: got %h/%0d/%b required 00000007/1/1", number_out, digit_count, number_valid); end
    checks++; if (nv_pulses - n0 !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d required 2", nv_pulses - n0); end
  endtask

  task automatic test_overflow();
    send_str("12345678");
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL ovf_eight_ok: got error=%b required 0", error); end
    send_char("9");
    checks++; if (error !== 1'b1 || err_code !== 2'd2) begin errors++; $display("FAIL ovf_error: got %b/%0d required 1/2", error, err_code); end
    send_char(CR);
    checks++; if (number_valid !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL ovf_term: got valid=%b error=%b required 0/0", number_valid, error); end
    checks++; if (number_out !== 32'h7 || busy !== 1'b0) begin errors++; $display("FAIL ovf_hold: got %h busy=%b required 00000007 busy=0", number_out, busy); end
  endtask

  task automatic test_invalid();
    send_str("12G");
    checks++; if (error !== 1'b1 || err_code !== 2'd1) begin errors++; $display("FAIL inv_error: got %b/%0d required 1/1", error, err_code); end
    send_char("4");
    send_char(CR);
    checks++; if (number_valid !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL inv_discard: got valid=%b error=%b required 0/0", number_valid, error); end
    send_char("5");
    send_char(CR);
    checks++; if (number_valid !== 1'b1 || number_out !== 32'h5 || digit_count !== 4'd1) begin errors++; $display("FAIL inv_recover: got %b/%h/%0d required 1/00000005/1", number_valid, number_out, digit_count); end
    checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL inv_code_hold: got %0d required 1", err_code); end
  endtask

  task automatic test_empty();
    int n0;
    send_str("0x");
    send_char(CR);
    checks++; if (error !== 1'b1 || err_code !== 2'd3 || number_valid !== 1'b0) begin errors++; $display("FAIL empty_prefix: got %b/%0d/%b required 1/3/0", error, err_code, number_valid); end
    send_char("0");
    send_char(CR);
    checks++; if (number_valid !== 1'b1 || number_out !== 32'h0 || digit_count !== 4'd1) begin errors++; $display("FAIL zero_value: got %b/%h/%0d required 1/00000000/1", number_valid, number_out, digit_count); end
    n0 = nv_pulses;
    send_char(CR);
    send_char(LF);
    checks++; if (nv_pulses !== n0 || error !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL empty_line: got pulses=%0d error=%b busy=%b required 0/0/0", nv_pulses - n0, error, busy); end
  endtask

  task automatic test_leading_zeros();
    send_str("00000000");
    send_char("1");
    checks++; if (error !== 1'b1 || err_code !== 2'd2) begin errors++; $display("FAIL lz_overflow: got %b/%0d required 1/2", error, err_code); end
    send_char(CR);
    send_str("0000000A");
    send_char(CR);
    checks++; if (number_out !== 32'hA || digit_count !== 4'd8) begin errors++; $display("FAIL lz_eight: got %h/%0d required 0000000a/8", number_out, digit_count); end
  endtask

  task automatic test_valid_gating();
    send_char("1");
    idle_cycle("G");
    idle_cycle(CR);
    send_char("2");
    send_char(CR);
    checks++; if (number_valid !== 1'b1 || number_out !== 32'h12 || digit_count !== 4'd2) begin errors++; $display("FAIL gating: got %b/%h/%0d required 1/00000012/2", number_valid, number_out, digit_count); end
    send_char("z");
    checks++; if (error !== 1'b1 || err_code !== 2'd1 || number_valid !== 1'b0) begin errors++; $display("FAIL invalid_after_valid: got %b/%0d/%b required 1/1/0", error, err_code, number_valid); end
    send_char(ESC);
    checks++; if (busy !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL esc_discard: got busy=%b error=%b required 0/0", busy, error); end
  endtask

  task automatic test_abort();
    send_str("AB");
    send_char(ESC);
    checks++; if (busy !== 1'b0 || error !== 1'b0 || number_valid !== 1'b0) begin errors++; $display("FAIL abort_quiet: got %b/%b/%b required 0/0/0", busy, error, number_valid); end
    checks++; if (number_out !== 32'h12) begin errors++; $display("FAIL abort_hold: got %h required 00000012", number_out); end
    send_char("C");
    send_char(CR);
    checks++; if (number_out !== 32'hC || digit_count !== 4'd1 || number_valid !== 1'b1) begin errors++; $display("FAIL abort_next: got %h/%0d/%b required 0000000c/1/1", number_out, digit_count, number_valid); end
  endtask

  task automatic test_reset_mid();
    send_str("12");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (number_out !== 32'h0 || digit_count !== 4'd0 || err_code !== 2'd0) begin errors++; $display("FAIL midreset_outputs: got %h/%0d/%0d required 0/0/0", number_out, digit_count, err_code); end
    checks++; if (busy !== 1'b0 || number_valid !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL midreset_flags: got %b/%b/%b required 0/0/0", busy, number_valid, error); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_char("3");
    send_char(CR);
    checks++; if (number_out !== 32'h3 || digit_count !== 4'd1 || number_valid !== 1'b1) begin errors++; $display("FAIL midreset_next: got %h/%0d/%b required 00000003/1/1", number_out, digit_count, number_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_invalid();
    test_empty();
    test_leading_zeros();
    test_valid_gating();
    test_abort();
    test_reset_mid();
    idle_cycle(8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hex_parser.md
Name: hex_parser

Overview:
- Inverse of the hex printer path: consumes a stream of ASCII characters, one byte per strobe, and parses a hexadecimal number into a 32-bit binary value.
- Sits behind the UART RX byte stream on the function-generator command interface and delivers numeric operands (frequency words, amplitudes) to the command decoder.
- A number is terminated by CR or LF. Result is presented with a one-cycle valid pulse; malformed input raises a one-cycle error pulse.

Parameters:
- MAX_DIGITS, 8, maximum hex digits accepted per number (1..8); result width is fixed at 32 bits.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- char_in  input  8  ASCII character
- char_valid  input  1  char_in is valid this cycle; one character is consumed per cycle, no backpressure
- number_out  output  32  last successfully parsed value, right-aligned, zero-extended
- number_valid  output  1  one-cycle pulse: number_out updated this cycle
- digit_count  output  4  digits in the last successful number
- error  output  1  one-cycle pulse on parse error
- err_code  output  2  cause of last error: 1 = invalid char, 2 = overflow, 3 = prefix with no digits; holds until next error
- busy  output  1  high while state != IDLE

Behaviour:
- Reset (async, rst_n low):
  - number_out = 0, digit_count = 0, err_code = 0.
  - number_valid = 0, error = 0.
  - state = IDLE, accumulator = 0, count = 0.
- Inputs are sampled only when char_valid = 1. All outputs are registered.
- Character classes:
  - hex digit: '0'-'9', 'A'-'F', 'a'-'f'
  - term: 0x0D, 0x0A
  - abort: ESC 0x1B
  - x: 'x' or 'X'
  - anything else is invalid
- States: IDLE, ZERO (leading '0' seen), ACCUM, DISCARD.
- IDLE:
  - '0': acc = 0, count = 1 -> ZERO.
  - other hex digit: acc = nibble, count = 1 -> ACCUM.
  - term: ignored; empty lines produce no output.
  - invalid: error, err_code = 1 -> DISCARD.
- ZERO:
  - x: acc = 0, count = 0, prefix flag set -> ACCUM.
  - hex digit: behaves as in ACCUM.
  - term: emits value 0 with digit_count = 1.
  - invalid: error (code 1) -> DISCARD.
- ACCUM:
  - hex digit with count < MAX_DIGITS: acc = {acc[27:0], nibble}, count++.
  - hex digit with count = MAX_DIGITS: error, err_code = 2 -> DISCARD.
  - term with count >= 1: number_out = acc, digit_count = count, number_valid pulses the cycle after the terminator is sampled -> IDLE.
  - term with count = 0 (bare "0x"): error, err_code = 3 -> IDLE.
  - invalid or x: error (code 1) -> DISCARD.
- DISCARD: all characters dropped until term -> IDLE. No number_valid.
- Abort: ESC in any state -> IDLE, acc and count cleared, no pulse, no error.
- Latency: exactly 1 cycle from the sampled terminator to number_valid or error.
- number_valid and error never assert in the same cycle.
- number_out holds its value across errors and aborts.
- Back-to-back numbers on consecutive cycles are supported; the cycle after a terminator may carry a new first digit.
- An invalid character in IDLE while the previous number_valid is pulsing is processed normally.
- Leading zeros count as digits, so "000000001" is an overflow.
- Reset mid-number discards the partial value.

Decomposition:
- Shared package hex_parser_pkg:
  - ASCII constants: CHAR_CR, CHAR_LF, CHAR_ESC, CHAR_0, CHAR_A, CHAR_a, CHAR_x, CHAR_X.
  - State encoding localparams.
  - ERR_INVALID / ERR_OVERFLOW / ERR_EMPTY codes.
- One sub-module, ascii_to_binary_hex: combinational char_in -> {is_hex, nibble[3:0]}. It is the exact inverse of binary_to_ascii_hex and is reused by other parsers.

Test Plan:
- Send "1A2b\r" -> number_valid 1 cycle after '\r'; number_out = 0x00001A2B, digit_count = 4, error never high.
- Send "0xDEADBEEF\n" then "7\n" back-to-back -> first 0xDEADBEEF (count 8), then 0x00000007 (count 1), two distinct pulses.
- Send "123456789\r" -> error on the 9th digit with err_code = 2; no number_valid at '\r'; number_out keeps its prior value.
- Send "12G4\r" -> error at 'G', err_code = 1, remaining chars discarded; then "5\r" -> 0x5 valid.
- Send "0x\r" -> error with err_code = 3. Send "0\r" -> value 0, count 1. Send "\r" alone -> no pulse.
- Send "AB" then ESC then "C\r" -> 0x0000000C. Assert rst_n low after "12" then "3\r" -> 0x00000003. All outputs are 0 during reset.
